// File: rtl/int_cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock, circular or hyperbolic,
// rotation or vectoring sub-mode, with valid/ready handshakes on both sides.
module int_cordic_iter #(
    parameter int unsigned int_width = 24,
    parameter int unsigned iters     = 16,
    parameter bit          mode      = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [int_width-1:0]        in_x,
    input  logic signed [int_width-1:0]        in_y,
    input  logic signed [int_width-1:0]        in_z,
    input  logic                               in_vectoring,
    output logic        [$clog2(int_width)-1:0] theta_idx,
    input  logic signed [int_width-1:0]        theta_val,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [int_width-1:0]        out_x,
    output logic signed [int_width-1:0]        out_y,
    output logic signed [int_width-1:0]        out_z,
    output logic                               busy
);

    localparam int unsigned W  = int_width;
    localparam int unsigned SW = $clog2(int_width);
    localparam int unsigned CW = $clog2(iters + 1);
    localparam logic [SW-1:0] S_FIRST = mode ? SW'(1) : SW'(0);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic signed [W-1:0] wx, wy, wz;
    logic                wvec;
    logic [SW-1:0]       shift;
    logic                rep_done;
    logic [CW-1:0]       step;

    logic                accept_c, last_c, d_c, x_add_c, rep_c;
    logic signed [W-1:0] xs_c, ys_c, x_step_c, y_step_c, z_step_c;

    assign in_ready  = (state == IDLE) && !rst;
    assign busy      = (state == RUN);
    assign theta_idx = (state == RUN) ? shift : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake strobes
    always_comb begin
        state_next = state;
        accept_c   = in_valid && in_ready;
        last_c     = (state == RUN) && (step == CW'(iters - 1));
        case (state)
            IDLE:    if (accept_c) state_next = RUN;
            RUN:     if (last_c) state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One micro-rotation from the current working registers
    always_comb begin
        xs_c     = wx >>> shift;
        ys_c     = wy >>> shift;
        d_c      = wvec ? wy[W-1] : (!wz[W-1] && (wz != '0));
        // Hyperbolic flips the sign of the x update relative to circular.
        x_add_c  = mode ? d_c : !d_c;
        x_step_c = x_add_c ? (wx + ys_c) : (wx - ys_c);
        y_step_c = d_c ? (wy + xs_c) : (wy - xs_c);
        z_step_c = d_c ? (wz - theta_val) : (wz + theta_val);
        rep_c    = mode && !rep_done &&
                   ((32'(shift) == 32'd4) || (32'(shift) == 32'd13));
    end

    // Working registers, shift schedule and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wx        <= '0;
            wy        <= '0;
            wz        <= '0;
            wvec      <= 1'b0;
            shift     <= '0;
            rep_done  <= 1'b0;
            step      <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept_c) begin
                wx       <= in_x;
                wy       <= in_y;
                wz       <= in_z;
                wvec     <= in_vectoring;
                shift    <= S_FIRST;
                rep_done <= 1'b0;
                step     <= '0;
            end else if (state == RUN) begin
                wx   <= x_step_c;
                wy   <= y_step_c;
                wz   <= z_step_c;
                step <= step + CW'(1);
                if (rep_c) begin
                    rep_done <= 1'b1;
                end else begin
                    shift    <= shift + SW'(1);
                    rep_done <= 1'b0;
                end
            end

            if (last_c) begin
                out_x     <= x_step_c;
                out_y     <= y_step_c;
                out_z     <= z_step_c;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
